// File: rtl/step_sequencer.sv
// Microcode step sequencer: one-hot step vector plus binary index, with jump-load,
// wrap/halt modes and a terminal-count pulse. Optional prescaler via STEP_SEQ_PRESCALE_EN.
module step_sequencer #(
  parameter  int STEPS    = 8,
  parameter  int PRESCALE = 4,
  localparam int SW       = $clog2(STEPS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             load,
  input  logic [SW-1:0]    load_step,
  input  logic             wrap_mode,
  output logic [STEPS-1:0] step_onehot,
  output logic [SW-1:0]    step_index,
  output logic             last_step,
  output logic             tc_pulse,
  output logic             halted,
  output logic             load_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef STEP_SEQ_PRESCALE_EN
  localparam int PS_DIV = PRESCALE;
`else
  // Divide-by-one: the counter never leaves zero, so every enabled cycle advances.
  localparam int PS_DIV = 1;
`endif

  localparam logic [PW-1:0]    PS_TERM = PW'(PS_DIV - 1);
  localparam logic [SW-1:0]    LAST    = SW'(STEPS - 1);
  localparam logic [SW:0]      NSTEPS  = (SW+1)'(STEPS);
  localparam logic [STEPS-1:0] ONEHOT0 = {{(STEPS-1){1'b0}}, 1'b1};

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [STEPS-1:0] onehot_q, onehot_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             load_ok;

  // Index is widened by one bit so non-power-of-two STEPS can flag out-of-range targets.
  assign load_ok = ({1'b0, load_step} < NSTEPS);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    onehot_d = onehot_q;
    tc_d     = 1'b0;
    err_d    = err_q;
    presc_d  = presc_q;
    if (restart) begin
      state_d  = S_RUN;
      step_d   = '0;
      onehot_d = ONEHOT0;
      presc_d  = '0;
    end else if (load) begin
      if (load_ok) begin
        state_d  = S_RUN;
        step_d   = load_step;
        onehot_d = ONEHOT0 << load_step;
        presc_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == S_RUN && enable) begin
      if (presc_q == PS_TERM) begin
        presc_d = '0;
        if (step_q == LAST) begin
          tc_d = 1'b1;
          if (wrap_mode) begin
            step_d   = '0;
            onehot_d = ONEHOT0;
          end else begin
            state_d = S_HALTED;
          end
        end else begin
          step_d   = step_q + 1'b1;
          onehot_d = {onehot_q[STEPS-2:0], 1'b0};
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      step_q   <= '0;
      onehot_q <= ONEHOT0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      onehot_q <= onehot_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
      presc_q  <= presc_d;
    end
  end

  assign step_onehot = onehot_q;
  assign step_index  = step_q;
  assign last_step   = (step_q == LAST);
  assign tc_pulse    = tc_q;
  assign halted      = (state_q == S_HALTED);
  assign load_err    = err_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: an 8-step instance for the main sequence and a
// 6-step instance so out-of-range loads are representable in the 3-bit load_step.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, restart, load, wrap_mode;
  logic [2:0] load_step;

  logic [7:0] oh8;
  logic [2:0] idx8;
  logic       last8, tc8, halt8, err8;
  logic [5:0] oh6;
  logic [2:0] idx6;
  logic       last6, tc6, halt6, err6;

  always #5 clk = ~clk;

  step_sequencer #(.STEPS(8), .PRESCALE(4)) u_dut8 (
    .clock(clk), .reset(reset), .enable(enable), .restart(restart), .load(load),
    .load_step(load_step), .wrap_mode(wrap_mode), .step_onehot(oh8), .step_index(idx8),
    .last_step(last8), .tc_pulse(tc8), .halted(halt8), .load_err(err8)
  );

  step_sequencer #(.STEPS(6), .PRESCALE(4)) u_dut6 (
    .clock(clk), .reset(reset), .enable(enable), .restart(restart), .load(load),
    .load_step(load_step), .wrap_mode(wrap_mode), .step_onehot(oh6), .step_index(idx6),
    .last_step(last6), .tc_pulse(tc6), .halted(halt6), .load_err(err6)
  );

  typedef struct {
    bit    d6;
    int    idx;
    bit    tc;
    bit    halt;
    bit    err;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Apply one cycle of inputs; the expectation describes outputs after the next edge.
  task automatic cyc(input bit rst, input bit en, input bit rs, input bit ld,
                     input logic [2:0] ls, input bit wr, input bit d6, input int idx,
                     input bit tc, input bit hl, input bit er, input string nm);
    exp_t e;
    reset = rst; enable = en; restart = rs; load = ld; load_step = ls; wrap_mode = wr;
    @(posedge clk);
    e.d6 = d6; e.idx = idx; e.tc = tc; e.halt = hl; e.err = er; e.nm = nm;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, compared at the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] got_oh, want_oh;
    int         got_idx;
    bit         got_last, got_tc, got_halt, got_err, want_last;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.d6) begin
          got_oh = {2'b00, oh6}; got_idx = int'(idx6); got_last = last6;
          got_tc = tc6; got_halt = halt6; got_err = err6;
          want_last = (e.idx == 5);
        end else begin
          got_oh = oh8; got_idx = int'(idx8); got_last = last8;
          got_tc = tc8; got_halt = halt8; got_err = err8;
          want_last = (e.idx == 7);
        end
        want_oh = 8'd1 << e.idx;
        checks++;
        if (got_oh !== want_oh || got_idx != e.idx || got_last !== want_last ||
            got_tc !== e.tc || got_halt !== e.halt || got_err !== e.err) begin
          errors++;
          $display("FAIL %s: got idx=%0d oh=%h last=%b tc=%b halt=%b err=%b, want idx=%0d oh=%h last=%b tc=%b halt=%b err=%b",
                   e.nm, got_idx, got_oh, got_last, got_tc, got_halt, got_err,
                   e.idx, want_oh, want_last, e.tc, e.halt, e.err);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; restart = 1'b0; load = 1'b0; load_step = 3'd0; wrap_mode = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset");
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_hold");
`ifdef STEP_SEQ_PRESCALE_EN
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "ps_count");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ps_adv1");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ps_gap");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ps_gap");
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ps_count2");
    cyc(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "ps_adv2");
    cyc(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "ps_partial");
    cyc(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "ps_partial");
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, "ps_restart");
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "ps_cleared");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ps_adv3");
`else
    for (int k = 1; k <= 9; k++) cyc(0, 1, 0, 0, 0, 1, 0, k % 8, (k == 8), 0, 0, "wrap_run");
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, "restart");
    for (int k = 1; k <= 7; k++) cyc(0, 1, 0, 0, 0, 0, 0, k, 0, 0, 0, "halt_run");
    cyc(0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, "halt_tc");
    cyc(0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, "halt_hold");
    cyc(0, 1, 0, 0, 0, 1, 0, 7, 0, 1, 0, "halt_hold_wrap");
    cyc(0, 1, 0, 1, 3, 0, 0, 3, 0, 0, 0, "halt_load");
    for (int k = 4; k <= 7; k++) cyc(0, 1, 0, 0, 0, 0, 0, k, 0, 0, 0, "rehalt_run");
    cyc(0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, "rehalt_tc");
    cyc(0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, "restart_over_load");
    cyc(0, 1, 0, 1, 2, 1, 0, 2, 0, 0, 0, "run_load");
    for (int k = 3; k <= 5; k++) cyc(0, 1, 0, 0, 0, 1, 0, k, 0, 0, 0, "to_step5");
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_mid");
    for (int k = 1; k <= 7; k++) cyc(0, 1, 0, 0, 0, 1, 0, k, 0, 0, 0, "to_last");
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_at_last");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "post_reset");
    // Six-step instance: load_step 6 and 7 are out of range.
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "d6_reset");
    cyc(0, 0, 1, 1, 6, 1, 1, 0, 0, 0, 0, "d6_restart_badload");
    cyc(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, "d6_run");
    cyc(0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, "d6_run");
    cyc(0, 1, 0, 1, 7, 1, 1, 2, 0, 0, 1, "d6_bad_load");
    cyc(0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 1, "d6_err_sticky");
    cyc(0, 0, 0, 1, 5, 1, 1, 5, 0, 0, 1, "d6_load5");
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, "d6_wrap_tc");
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, "d6_restart_keeps_err");
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "d6_err_clear");
`endif
    reset = 1'b0; enable = 1'b0; restart = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
